// File: rtl/fp_pkg.sv
// Shared types, flag positions and format helpers for the pipelined FP multiplier.
package fp_pkg;

  typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_t;

  // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Exponent bias for an exponent field of exp_w bits
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  // Returned right-aligned in 64 bits; callers truncate to their word width.
  function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result bundle of the pipelined FP multiplier.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The sender holds valid and its payload stable until that
// edge; ready may depend on the far-side ready but never on this side's valid.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     dataa;
  logic [W-1:0]     datab;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       flags;

  modport master (
    output in_valid, dataa, datab, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, flags
  );

  modport slave (
    input  in_valid, dataa, datab, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, flags
  );
endinterface

// File: rtl/fp_mul_stage_ctl.sv
// Per-stage valid bits and load enables for a DEPTH-deep elastic pipeline.
// A stage loads when it is empty or its successor loads, so bubbles collapse
// and the whole chain stalls only when the consumer refuses a full pipe.
module fp_mul_stage_ctl #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic [DEPTH-1:0] load,
  output logic [DEPTH-1:0] valid
);

  logic [DEPTH-1:0] feed;

  assign feed = {valid[DEPTH-2:0], in_valid};

  // Load enables ripple back from the consumer; in_valid takes no part here
  always_comb begin
    logic chain;
    load  = '0;
    chain = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      load[k] = ~valid[k] | chain;
      chain   = load[k];
    end
  end

  // Each loading stage takes its predecessor's valid; held stages keep theirs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid <= '0;
    else          valid <= (valid & ~load) | (feed & load);
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE754 multiplier: unpack/classify, (MUL_REGS+1)-stage mantissa
// multiply, then normalise/round-to-nearest-even/pack. Subnormals are flushed
// to zero on input and output. Latency is 3+MUL_REGS cycles, one op per cycle.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int MUL_REGS = 0,
  parameter int TAG_W    = 4
) (
  input logic          clk,
  input logic          reset_n,
  fp_mul_pipe_if.slave bus
);

  localparam int W        = 1 + EXP_W + MAN_W;   // at most 64 bits
  localparam int L        = 3 + MUL_REGS;
  localparam int LAST     = L - 1;
  localparam int MUL_LAST = L - 2;
  localparam int SW       = EXP_W + 2;           // signed working exponent
  localparam int MW       = MAN_W + 1;
  localparam int PW       = 2 * MW;

  localparam logic [W-1:0]  NAN_WORD = W'(canonical_nan(EXP_W, MAN_W));
  localparam logic [SW-1:0] BIAS_V   = SW'(bias(EXP_W));
  localparam logic signed [SW-1:0] EXP_MAX = SW'((1 << EXP_W) - 1);

  // Everything that travels alongside the mantissa product
  typedef struct packed {
    logic             sign;
    logic [SW-1:0]    exp;
    logic             special;
    logic [W-1:0]     special_word;
    logic [3:0]       special_flags;
    logic [TAG_W-1:0] tag;
  } side_t;

  logic [L-1:0] load;
  logic [L-1:0] valid;

  fp_mul_stage_ctl #(.DEPTH(L)) u_ctl (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .load      (load),
    .valid     (valid)
  );

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid[LAST];

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] m);
    if (e == '0) return ZERO;          // zero or subnormal
    if (e == '1) begin
      if (m == '0) return INF;
      return m[MAN_W-1] ? QNAN : SNAN;
    end
    return NORM;
  endfunction

  // ---------------- S1: unpack / classify / resolve special operands
  fp_class_t      cls_a, cls_b;
  logic           nan_in, snan_in, inf_zero, inf_in, zero_in;
  side_t          s1_d;
  logic [MW-1:0]  ma_d, mb_d;

  // Decide specials up front so later stages only need a single select
  always_comb begin
    cls_a    = classify(bus.dataa[W-2 -: EXP_W], bus.dataa[MAN_W-1:0]);
    cls_b    = classify(bus.datab[W-2 -: EXP_W], bus.datab[MAN_W-1:0]);
    nan_in   = (cls_a == QNAN) || (cls_a == SNAN) || (cls_b == QNAN) || (cls_b == SNAN);
    snan_in  = (cls_a == SNAN) || (cls_b == SNAN);
    inf_zero = ((cls_a == INF) && (cls_b == ZERO)) || ((cls_a == ZERO) && (cls_b == INF));
    inf_in   = (cls_a == INF) || (cls_b == INF);
    zero_in  = (cls_a == ZERO) || (cls_b == ZERO);
    ma_d     = {1'b1, bus.dataa[MAN_W-1:0]};
    mb_d     = {1'b1, bus.datab[MAN_W-1:0]};

    s1_d      = '0;
    s1_d.sign = bus.dataa[W-1] ^ bus.datab[W-1];
    s1_d.exp  = SW'(bus.dataa[W-2 -: EXP_W]) + SW'(bus.datab[W-2 -: EXP_W]) - BIAS_V;
    s1_d.tag  = bus.in_tag;
    if (nan_in || inf_zero) begin
      s1_d.special                     = 1'b1;
      s1_d.special_word                = NAN_WORD;
      s1_d.special_flags[FLAG_INVALID] = snan_in || inf_zero;
    end else if (inf_in) begin
      s1_d.special      = 1'b1;
      s1_d.special_word = {s1_d.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_in) begin
      s1_d.special      = 1'b1;
      s1_d.special_word = {s1_d.sign, {(W-1){1'b0}}};
    end
  end

  // ---------------- S1 register and S2 multiply pipeline
  side_t         sb   [0:MUL_LAST];
  logic [PW-1:0] prod [0:MUL_REGS];   // prod[j] belongs to stage j+1
  logic [MW-1:0] ma_q, mb_q;

  // Advance sideband and product only where a stage loads real data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= MUL_LAST; k++) sb[k] <= '0;
      for (int j = 0; j <= MUL_REGS; j++) prod[j] <= '0;
      ma_q <= '0;
      mb_q <= '0;
    end else begin
      if (load[0] && bus.in_valid) begin
        sb[0] <= s1_d;
        ma_q  <= ma_d;
        mb_q  <= mb_d;
      end
      if (load[1] && valid[0]) begin
        sb[1]   <= sb[0];
        prod[0] <= PW'(ma_q) * PW'(mb_q);
      end
      for (int j = 1; j <= MUL_REGS; j++) begin
        if (load[j+1] && valid[j]) begin
          sb[j+1] <= sb[j];
          prod[j] <= prod[j-1];
        end
      end
    end
  end

  // ---------------- S3: normalise / round / pack
  side_t          s3;
  logic [PW-1:0]  p;
  logic [PW-2:0]  nrm;               // product with the hidden bit removed
  logic           msb, guard, sticky, round_up;
  logic [MAN_W-1:0] frac;
  logic [MAN_W:0]   frac_r;
  logic [SW-1:0]    e_r;
  logic [W-1:0]     res_d;
  logic [3:0]       flags_d;

  // Round to nearest even, then apply overflow and flush-to-zero limits
  always_comb begin
    s3       = sb[MUL_LAST];
    p        = prod[MUL_REGS];
    msb      = p[PW-1];
    nrm      = msb ? p[PW-2:0] : {p[PW-3:0], 1'b0};
    frac     = nrm[PW-2 -: MAN_W];
    guard    = nrm[MAN_W];
    sticky   = |nrm[MAN_W-1:0];
    round_up = guard & (sticky | frac[0]);
    frac_r   = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    e_r      = s3.exp + {{(SW-1){1'b0}}, msb} + {{(SW-1){1'b0}}, frac_r[MAN_W]};

    res_d   = '0;
    flags_d = '0;
    if (s3.special) begin
      res_d   = s3.special_word;
      flags_d = s3.special_flags;
    end else if ($signed(e_r) >= EXP_MAX) begin
      res_d                  = {s3.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d[FLAG_OVERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT]  = 1'b1;
    end else if ($signed(e_r) <= 0) begin
      res_d                   = {s3.sign, {(W-1){1'b0}}};
      flags_d[FLAG_UNDERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT]   = 1'b1;
    end else begin
      res_d                 = {s3.sign, e_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
      flags_d[FLAG_INEXACT] = guard | sticky;
    end
  end

  logic [W-1:0]     res_q;
  logic [TAG_W-1:0] tag_q;
  logic [3:0]       flags_q;

  // Output register holds steady while the consumer stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q   <= '0;
      tag_q   <= '0;
      flags_q <= '0;
    end else if (load[LAST] && valid[MUL_LAST]) begin
      res_q   <= res_d;
      tag_q   <= s3.tag;
      flags_q <= flags_d;
    end
  end

  assign bus.result  = res_q;
  assign bus.out_tag = tag_q;
  assign bus.flags   = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe at default parameters (binary32, MUL_REGS=0).
module tb_fp_mul_pipe;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int MUL_REGS = 0;
  localparam int TAG_W    = 4;
  localparam int W        = 1 + EXP_W + MAN_W;
  localparam int L        = 3 + MUL_REGS;
  localparam int EW       = W + TAG_W + 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  bit   chk_lat  = 1'b0;
  bit   rnd_done = 1'b0;

  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  logic [EW-1:0] mon_e;

  fp_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .MUL_REGS(MUL_REGS), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / cycle count / watchdog
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, want);
  endtask

  // Reference multiply for normal operands whose product stays normal
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           output logic [3:0] f);
    logic [47:0] p, q, rem, half;
    int e, sh;
    p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = p[47] ? 24 : 23;
    if (p[47]) e++;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 48'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 48'd1;
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    f = (rem != 48'd0) ? 4'b0001 : 4'b0000;
    return {a[31] ^ b[31], e[7:0], q[22:0]};
  endfunction

  // ---------------- driver: present one op, push its expectation on acceptance
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TAG_W-1:0] t,
                      input logic [W-1:0] er, input logic [3:0] ef);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.dataa    = a;
    bus.datab    = b;
    bus.in_tag   = t;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back({er, t, ef});
        lat_q.push_back(chk_lat ? cyc : -1);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor: compare head while valid, pop on transfer
  always @(negedge clk) begin
    if (reset_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        mon_e = exp_q[0];
        check(bus.out_ready ? "result" : "hold_result", 64'(bus.result), 64'(mon_e[EW-1 -: W]));
        check(bus.out_ready ? "tag" : "hold_tag", 64'(bus.out_tag), 64'(mon_e[TAG_W+3:4]));
        check(bus.out_ready ? "flags" : "hold_flags", 64'(bus.flags), 64'(mon_e[3:0]));
        if (bus.out_ready) begin
          if (lat_q[0] >= 0) check("latency", 64'(cyc - lat_q[0]), 64'(L));
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          n_out++;
        end
      end
    end
  end

  // ---------------- directed table
  logic [W-1:0] da [12] = '{32'h3FC00000, 32'h3FC00000, 32'h3F800001, 32'h7F800000,
                            32'hFF800000, 32'h7F7FFFFF, 32'h00800000, 32'h00000001,
                            32'h7F800001, 32'h7FC00000, 32'h00000000, 32'hFF800000};
  logic [W-1:0] db [12] = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h00000000,
                            32'h40000000, 32'h40000000, 32'hBF000000, 32'h3F800000,
                            32'h3F800000, 32'h3F800000, 32'hC0000000, 32'h7F800000};
  logic [W-1:0] dr [12] = '{32'h40400000, 32'h3FC00002, 32'h3F800002, 32'h7FC00000,
                            32'hFF800000, 32'h7F800000, 32'h80000000, 32'h00000000,
                            32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'hFF800000};
  logic [3:0]   df [12] = '{4'h0, 4'h1, 4'h1, 4'h8, 4'h0, 4'h5, 4'h3, 4'h0,
                            4'h8, 4'h0, 4'h0, 4'h0};

  int n_before;

  initial begin
    bus.in_valid  = 1'b0;
    bus.dataa     = '0;
    bus.datab     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // reset state
    #2;
    check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_out_tag", 64'(bus.out_tag), 64'd0);
    check("reset_flags", 64'(bus.flags), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // directed values, back to back, no stall: latency checked on each
    chk_lat = 1'b1;
    for (int i = 0; i < 12; i++)
      send(da[i], db[i], (i == 0) ? 4'd5 : 4'(i), dr[i], df[i]);
    wait_drain();
    chk_lat = 1'b0;

    // backpressure: 10 ops, consumer stalls 6 cycles mid-stream
    n_before = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(32'h3F800000 + 32'(i), 32'h40000000, 4'(i), 32'h40000000 + 32'(i), 4'h0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
        check("bp_out_valid_held", {63'd0, bus.out_valid}, 64'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_delivered", 64'(n_out - n_before), 64'd10);

    // random normal operands with random gaps and random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [W-1:0] a, b, r;
          logic [3:0] f;
          a = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
          b = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
          r = ref_mul(a, b, f);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(a, b, 4'(i), r, f);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // asynchronous reset with three ops in flight
    send(32'h3FC00000, 32'h3F800001, 4'hA, 32'h3FC00002, 4'h1);
    send(32'h3FC00000, 32'h3F800001, 4'hB, 32'h3FC00002, 4'h1);
    send(32'h3FC00000, 32'h3F800001, 4'hC, 32'h3FC00002, 4'h1);
    reset_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    check("midrst_flags", 64'(bus.flags), 64'd0);
    check("midrst_out_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_midrst", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send(32'h40400000, 32'h40000000, 4'h3, 32'h40C00000, 4'h0);
    wait_drain();
    chk_lat = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Pipelined, parametrised IEEE754 binary floating-point multiplier with valid/ready handshakes on input and output; successor to the single-cycle combinational FP multiplier.
- Accepts one operand pair per cycle, applies round-to-nearest-even, produces exception flags, and carries a user tag through unchanged.
- Sits between the accelerator's operand fetch stage and its accumulate/writeback stage in the neural-network datapath.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored mantissa width (excludes the hidden bit). Word width W = 1+EXP_W+MAN_W.
- MUL_REGS, 0: extra register stages inside the mantissa multiply (0..2). Total latency L = 3+MUL_REGS.
- TAG_W, 4: width of the pass-through tag.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept this cycle.
- dataa  in  W  operand A.
- datab  in  W  operand B.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- result  out  W  product.
- out_tag  out  TAG_W  tag of this result.
- flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Assertion clears every stage valid at once, including mid-operation; in-flight operations are discarded. Reset values: out_valid=0, result=0, out_tag=0, flags=0. in_ready=1 from the first cycle after release.
- Transfers: an input transfer occurs when in_valid&in_ready, and an output transfer when out_valid&out_ready. Results leave in input order, and each result's tag equals its input tag.
- Stages and stall rule: each stage has its own valid. Stage k loads when it is empty or stage k+1 loads (for the last stage, when out_ready is high). Bubbles collapse. in_ready is stage-0 load-enable, which is combinational from out_ready through the stage valids; there is no combinational path from in_valid to in_ready.
- Throughput and latency: throughput is 1/cycle when out_ready=1. A result appears L cycles after acceptance with no stall.
- While out_valid=1 and out_ready=0: result, out_tag and flags are held stable.
- S1 (unpack/classify):
  - Subnormal inputs are treated as zero (DAZ).
  - Classes are zero, normal, inf and NaN.
  - Output sign = signA ^ signB.
  - Unbiased exponent sum is held signed in EXP_W+2 bits: ea+eb-BIAS, where BIAS = 2^(EXP_W-1)-1.
- S2 (multiply): (MAN_W+1)x(MAN_W+1) product, registered MUL_REGS+1 times.
- S3 (normalise/round/pack):
  - If the product MSB is set, shift right 1 and increment the exponent.
  - Guard = first dropped bit; sticky = OR of the rest. Round up when guard & (sticky | lsb).
  - A rounding carry-out renormalises: mantissa=0, exponent+1.
  - inexact = guard | sticky.
- Special cases, in priority order:
  - Either input NaN, or inf×0: canonical quiet NaN (sign 0, exponent all-ones, mantissa MSB=1, rest 0; 0x7FC00000 at defaults). invalid=1 only for inf×0 or a signalling-NaN input.
  - inf×finite-nonzero: ±inf, no flags.
  - Either input zero (after DAZ): ±0, no flags.
  - Rounded exponent ≥ all-ones: ±inf, overflow=1, inexact=1.
  - Rounded exponent ≤ 0: ±0 (FTZ), underflow=1, inexact=1.

Decomposition:
- Package fp_pkg holds:
  - fp_class_t enum {ZERO, NORM, INF, QNAN, SNAN};
  - flag bit indices;
  - functions bias(EXP_W) and canonical_nan(EXP_W, MAN_W).
- One sub-module, fp_mul_stage_ctl: a parametrised per-stage valid/load-enable chain of depth L, reused by the datapath registers.

Test Plan:
- 0x3FC00000 × 0x40000000, tag 5, out_ready=1 → 0x40400000, tag 5, flags 0, exactly 3 cycles later (MUL_REGS=0).
- 0x3FC00000 × 0x3F800001 (tie) → 0x3FC00002, inexact=1; 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1.
- Special values:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
  - 0x7F7FFFFF × 0x40000000 → 0x7F800000, overflow=1, inexact=1.
- Underflow and signed zero: 0x00800000 × 0xBF000000 → 0x80000000, underflow=1, inexact=1. Subnormal 0x00000001 × 0x3F800000 → 0x00000000, flags 0.
- Backpressure: stream 10 ops with incrementing tags, hold out_ready=0 for 6 cycles mid-stream → in_ready falls once L results are queued; outputs stay held; all 10 results are delivered in tag order with none lost or duplicated.
- Reset mid-operation: assert reset_n=0 with 3 ops in flight → out_valid=0, result=0 and flags=0 immediately (asynchronous). After release, the first new op completes in L cycles and no stale result appears.
